cv32e40n_apu_responder: RTL and testbench

Parametrised APU-side responder for the CV32E40 APU port. It replaces the fixed-latency dummy responder with one that performs real work. Integer operations complete after a configurable latency. Load/store operations run a real transaction on the shared data-memory interface and claim it through `mem_master_sel`. The block sits on the core's APU request/response channel and on the data-memory mux, exactly where the dummy responder sat.

---
 rtl/cv32e40n_apu_responder.sv | 173 +++++++++++++++++
 tb/tb_cv32e40n_apu_responder.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40n_apu_responder.sv
// APU-side responder for the CV32E40 APU port.
// Compute ops (ADD/XOR) finish after LATENCY cycles. Load/store ops run one
// transaction on the shared data-memory port while holding mem_master_sel.

package cv32e40p_apu_core_pkg;
  parameter int APU_NARGS_CPU    = 3;
  parameter int APU_WOP_CPU      = 6;
  parameter int APU_NDSFLAGS_CPU = 15;
  parameter int APU_NUSFLAGS_CPU = 5;
endpackage

// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a request, apu_gnt_o high
// EXEC     | compute op (or load/store with MEM_EN=0), counter runs to 0
// MEM_REQ  | data_req_o high, request fields held until data_gnt_i
// MEM_WAIT | request granted, waiting for data_rvalid_i
// RESP     | apu_rvalid_o pulse, apu_result_o valid
module cv32e40n_apu_responder
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int MEM_EN  = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [APU_NARGS_CPU-1:0][31:0]     apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]             apu_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]        apu_flags_i,
  input  logic                               apu_req_i,
  output logic                               apu_gnt_o,
  output logic                               apu_rvalid_o,
  output logic [31:0]                        apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]        apu_flags_o,
  output logic                               mem_master_sel,
  output logic                               data_req_o,
  input  logic                               data_gnt_i,
  input  logic                               data_rvalid_i,
  output logic                               data_we_o,
  output logic [3:0]                         data_be_o,
  output logic [31:0]                        data_addr_o,
  output logic [31:0]                        data_wdata_o,
  input  logic [31:0]                        data_rdata_i
);

  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $error("cv32e40n_apu_responder: LATENCY must be within 1..16");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    RESP     = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_XOR   = 2'd3;

  localparam bit         MemOn   = (MEM_EN != 0);
  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] op0_q, op1_q;
  logic [31:0] result_q, result_d;
  logic        result_we;
  logic [31:0] exec_result;
  logic        accept;
  logic        is_mem_op;

  // Flags and unused operand/opcode bits carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{apu_flags_i, apu_op_i, apu_operands_i};

  // Grant is also masked by reset so every output reads 0 while rst_ni is low.
  assign apu_gnt_o      = rst_ni & (state_q == IDLE);
  assign accept         = apu_req_i & apu_gnt_o;
  assign is_mem_op      = (apu_op_i[1:0] == OP_LOAD) || (apu_op_i[1:0] == OP_STORE);

  assign apu_rvalid_o   = (state_q == RESP);
  assign apu_result_o   = result_q;
  assign apu_flags_o    = '0;

  assign mem_master_sel = MemOn & ((state_q == MEM_REQ) || (state_q == MEM_WAIT));
  assign data_req_o     = MemOn & (state_q == MEM_REQ);
  assign data_we_o      = data_req_o & (op_q == OP_STORE);
  assign data_be_o      = data_req_o ? 4'hF : 4'h0;
  assign data_addr_o    = data_req_o ? {op0_q[31:2], 2'b00} : 32'h0;
  assign data_wdata_o   = data_we_o ? op1_q : 32'h0;

  // Compute result; load/store reaching EXEC (MEM_EN=0) yields 0.
  always_comb begin
    exec_result = 32'h0;
    case (op_q)
      OP_ADD:  exec_result = op0_q + op1_q;
      OP_XOR:  exec_result = op0_q ^ op1_q;
      default: exec_result = 32'h0;
    endcase
  end

  // Next-state and result-write decode.
  always_comb begin
    state_d   = state_q;
    result_we = 1'b0;
    result_d  = exec_result;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (is_mem_op && MemOn) ? MEM_REQ : EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          result_we = 1'b1;
          result_d  = exec_result;
          state_d   = RESP;
        end
      end
      MEM_REQ: begin
        if (data_gnt_i) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (data_rvalid_i) begin
          result_we = 1'b1;
          result_d  = (op_q == OP_LOAD) ? data_rdata_i : 32'h0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight transaction immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, latency down-counter and result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= 4'd0;
      op_q     <= 2'd0;
      op0_q    <= 32'h0;
      op1_q    <= 32'h0;
      result_q <= 32'h0;
    end else begin
      if (accept) begin
        op_q  <= apu_op_i[1:0];
        op0_q <= apu_operands_i[0];
        op1_q <= apu_operands_i[1];
        cnt_q <= CntInit;
      end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (result_we) begin
        result_q <= result_d;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40n_apu_responder.sv
// Scoreboard bench for cv32e40n_apu_responder: instance A (LATENCY=1, memory
// enabled) with a bench memory responder, instance B (LATENCY=5, MEM_EN=0).
module tb_cv32e40n_apu_responder;
  import cv32e40p_apu_core_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // APU side, index 0 = instance A, 1 = instance B
  logic [APU_NARGS_CPU-1:0][31:0] operands [2];
  logic [APU_WOP_CPU-1:0]         op       [2];
  logic [APU_NDSFLAGS_CPU-1:0]    flags_in [2];
  logic                           req      [2];
  logic                           gnt      [2];
  logic                           rvalid   [2];
  logic [31:0]                    result   [2];
  logic [APU_NUSFLAGS_CPU-1:0]    flags_out[2];
  logic                           msel     [2];

  // memory side
  logic dreq_a, dgnt_a, drvalid_a, dwe_a;
  logic [3:0] dbe_a;
  logic [31:0] daddr_a, dwdata_a, drdata_a;
  logic dreq_b, dgnt_b, drvalid_b, dwe_b;
  logic [3:0] dbe_b;
  logic [31:0] daddr_b, dwdata_b, drdata_b;

  cv32e40n_apu_responder #(.LATENCY(LAT_A), .MEM_EN(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .apu_operands_i(operands[0]), .apu_op_i(op[0]), .apu_flags_i(flags_in[0]),
    .apu_req_i(req[0]), .apu_gnt_o(gnt[0]), .apu_rvalid_o(rvalid[0]),
    .apu_result_o(result[0]), .apu_flags_o(flags_out[0]), .mem_master_sel(msel[0]),
    .data_req_o(dreq_a), .data_gnt_i(dgnt_a), .data_rvalid_i(drvalid_a),
    .data_we_o(dwe_a), .data_be_o(dbe_a), .data_addr_o(daddr_a),
    .data_wdata_o(dwdata_a), .data_rdata_i(drdata_a)
  );

  cv32e40n_apu_responder #(.LATENCY(LAT_B), .MEM_EN(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .apu_operands_i(operands[1]), .apu_op_i(op[1]), .apu_flags_i(flags_in[1]),
    .apu_req_i(req[1]), .apu_gnt_o(gnt[1]), .apu_rvalid_o(rvalid[1]),
    .apu_result_o(result[1]), .apu_flags_o(flags_out[1]), .mem_master_sel(msel[1]),
    .data_req_o(dreq_b), .data_gnt_i(dgnt_b), .data_rvalid_i(drvalid_b),
    .data_we_o(dwe_b), .data_be_o(dbe_b), .data_addr_o(daddr_b),
    .data_wdata_o(dwdata_b), .data_rdata_i(drdata_b)
  );

  typedef struct { int dut; logic [31:0] res; int unsigned due; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
                   logic we; int dg; int dr; } mem_t;
  exp_t sb[$];
  mem_t mq[$];

  bit   prev_hold    [2];
  bit   prev_compute [2];
  logic [31:0] last_res [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what an operation should return and when.
  function automatic int lat(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic bit mem_en(input int d);
    return d == 0;
  endfunction

  function automatic logic [31:0] ref_result(input int d, input logic [1:0] o,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] rdata);
    case (o)
      2'd0:    return a + b;
      2'd3:    return a ^ b;
      2'd1:    return mem_en(d) ? rdata : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int unsigned ref_due(input int d, input logic [1:0] o,
                                          input int unsigned acc, input int dg, input int dr);
    if (mem_en(d) && (o == 2'd1 || o == 2'd2)) return acc + 3 + dg + dr;
    return acc + 1 + lat(d);
  endfunction

  // Drive one request, wait for its accept, record the expected response.
  task automatic issue(input int d, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int dg, input int dr,
                       input logic [31:0] rdata, input bit hold);
    int t;
    int unsigned acc;
    exp_t e;
    mem_t m;
    operands[d][0] = a;
    operands[d][1] = b;
    for (int i = 2; i < APU_NARGS_CPU; i++) operands[d][i] = $urandom;
    op[d]       = APU_WOP_CPU'($urandom);
    op[d][1:0]  = o;
    flags_in[d] = APU_NDSFLAGS_CPU'($urandom);
    req[d]      = 1'b1;
    t = 0;
    while (!gnt[d] && t < 64) begin
      @(negedge clk);
      t++;
    end
    check1("accept_within_bound", gnt[d], 1'b1);
    if (!gnt[d]) begin
      req[d] = 1'b0;
      prev_hold[d] = 1'b0;
      return;
    end
    if (prev_hold[d] && prev_compute[d]) check("b2b_accept_spacing", t, lat(d) + 1);
    acc = cyc;
    e.dut = d;
    e.res = ref_result(d, o, a, b, rdata);
    e.due = ref_due(d, o, acc, dg, dr);
    if (dr >= 0) sb.push_back(e);
    if (mem_en(d) && (o == 2'd1 || o == 2'd2)) begin
      m.addr = a; m.wdata = b; m.rdata = rdata; m.we = (o == 2'd2);
      m.dg = dg; m.dr = dr;
      mq.push_back(m);
    end
    @(negedge clk);
    check1("gnt_low_after_accept", gnt[d], 1'b0);
    if (!hold) req[d] = 1'b0;
    prev_hold[d]    = hold;
    prev_compute[d] = !mem_en(d) || o == 2'd0 || o == 2'd3;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_outstanding", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input int d, input string tag);
    check1({tag, "_gnt"}, gnt[d], 1'b0);
    check1({tag, "_rvalid"}, rvalid[d], 1'b0);
    check({tag, "_result"}, result[d], 32'h0);
    check({tag, "_flags"}, 32'(flags_out[d]), 32'h0);
    check1({tag, "_msel"}, msel[d], 1'b0);
    check1({tag, "_dreq"}, d == 0 ? dreq_a : dreq_b, 1'b0);
    check1({tag, "_dwe"}, d == 0 ? dwe_a : dwe_b, 1'b0);
    check({tag, "_dbe"}, 32'(d == 0 ? dbe_a : dbe_b), 32'h0);
    check({tag, "_daddr"}, d == 0 ? daddr_a : daddr_b, 32'h0);
    check({tag, "_dwdata"}, d == 0 ? dwdata_a : dwdata_b, 32'h0);
  endtask

  // Monitor: pop and compare on every apu_rvalid_o pulse.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        last_res[d] = 32'h0;
      end else if (rvalid[d]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rvalid dut%0d: pulse with result 0x%08h, required no pulse", d, result[d]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rvalid_dut", d, e.dut);
          check("result", result[d], e.res);
          check("rvalid_cycle", cyc, e.due);
          check1("gnt_in_resp", gnt[d], 1'b0);
          check("flags_out", 32'(flags_out[d]), 32'h0);
        end
        last_res[d] = result[d];
      end else begin
        check("result_hold", result[d], last_res[d]);
      end
    end
  end

  // Memory responder for instance A, with programmable gnt/rvalid delays.
  initial begin : mem_responder
    mem_t m;
    dgnt_a = 1'b0; drvalid_a = 1'b0; drdata_a = 32'h0;
    forever begin
      @(negedge clk);
      dgnt_a = 1'b0;
      drvalid_a = 1'b0;
      if (rst_n && dreq_a) begin
        if (mq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_data_req: addr 0x%08h, required no request", daddr_a);
          continue;
        end
        m = mq.pop_front();
        check("req_addr", daddr_a, {m.addr[31:2], 2'b00});
        check("req_be", 32'(dbe_a), 32'hF);
        check1("req_we", dwe_a, m.we);
        if (m.we) check("req_wdata", dwdata_a, m.wdata);
        check1("msel_req", msel[0], 1'b1);
        for (int i = 0; i < m.dg; i++) begin
          drvalid_a = 1'($urandom_range(0, 1));
          drdata_a  = $urandom;
          @(negedge clk);
          drvalid_a = 1'b0;
          check1("stall_req", dreq_a, 1'b1);
          check("stall_addr", daddr_a, {m.addr[31:2], 2'b00});
          check("stall_be", 32'(dbe_a), 32'hF);
          check1("stall_we", dwe_a, m.we);
          if (m.we) check("stall_wdata", dwdata_a, m.wdata);
          check1("msel_stall", msel[0], 1'b1);
        end
        dgnt_a = 1'b1;
        @(negedge clk);
        dgnt_a = 1'b0;
        check1("req_after_gnt", dreq_a, 1'b0);
        check1("msel_wait", msel[0], 1'b1);
        if (m.dr < 0) begin
          for (int i = 0; i < 200 && rst_n; i++) @(negedge clk);
        end else begin
          for (int i = 0; i < m.dr; i++) begin
            @(negedge clk);
            check1("msel_wait", msel[0], 1'b1);
          end
          drvalid_a = 1'b1;
          drdata_a  = m.rdata;
          @(negedge clk);
          drvalid_a = 1'b0;
          drdata_a  = $urandom;
        end
      end else if (rst_n) begin
        check1("msel_idle", msel[0], 1'b0);
        check("bus_idle_ctrl", {27'h0, dreq_a, dwe_a, dbe_a[2:0]} | 32'(dbe_a), 32'h0);
        check("bus_idle_addr", daddr_a | dwdata_a, 32'h0);
        drvalid_a = 1'($urandom_range(0, 3) == 0);
        drdata_a  = $urandom;
      end
    end
  end

  // Instance B memory port: random noise, must never be used.
  initial begin : noise_b
    dgnt_b = 1'b0; drvalid_b = 1'b0; drdata_b = 32'h0;
    forever begin
      @(negedge clk);
      dgnt_b    = 1'($urandom_range(0, 1));
      drvalid_b = 1'($urandom_range(0, 1));
      drdata_b  = $urandom;
      if (rst_n) begin
        check1("b_msel", msel[1], 1'b0);
        check1("b_dreq", dreq_b, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [1:0] o;
    for (int d = 0; d < 2; d++) begin
      operands[d] = '0; op[d] = '0; flags_in[d] = '0; req[d] = 1'b0;
      prev_hold[d] = 1'b0; prev_compute[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero(0, "reset_a");
    check_outputs_zero(1, "reset_b");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check1("gnt_after_reset_a", gnt[0], 1'b1);
    check1("gnt_after_reset_b", gnt[1], 1'b1);

    // instance A directed
    issue(0, 2'd0, 32'hFFFF_FFFF, 32'h2, 0, 0, 32'h0, 1'b0);
    drain();
    issue(0, 2'd1, 32'h1000_0006, $urandom, 3, 2, 32'hDEAD_BEEF, 1'b0);
    drain();
    issue(0, 2'd2, 32'h0000_0020, 32'h1234_5678, 0, 0, $urandom, 1'b0);
    drain();
    issue(0, 2'd1, $urandom, $urandom, 0, 0, $urandom, 1'b0);
    drain();

    // instance A back-to-back compute with request held
    for (int k = 0; k < 5; k++) begin
      o = (k % 2 == 0) ? 2'd0 : 2'd3;
      issue(0, o, $urandom, $urandom, 0, 0, 32'h0, k < 4);
    end
    drain();

    // instance A random mix
    for (int k = 0; k < 60; k++) begin
      o = 2'($urandom_range(0, 3));
      issue(0, o, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
            $urandom, (k < 59) && ($urandom_range(0, 2) == 0));
    end
    req[0] = 1'b0;
    prev_hold[0] = 1'b0;
    drain();

    // reset while in MEM_WAIT
    issue(0, 2'd1, 32'h0000_0100, $urandom, 1, -1, $urandom, 1'b0);
    repeat (3) @(negedge clk);
    check1("pre_reset_msel", msel[0], 1'b1);
    check1("pre_reset_dreq", dreq_a, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero(0, "midreset_a");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    mq.delete();
    @(negedge clk);
    check1("gnt_after_midreset", gnt[0], 1'b1);
    issue(0, 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h0, 1'b0);
    drain();

    // instance B: long latency XOR, gnt must stay low until RESP is over
    issue(1, 2'd3, 32'hA5A5_0000, 32'h0F0F_FFFF, 0, 0, 32'h0, 1'b0);
    repeat (LAT_B) begin
      @(negedge clk);
      check1("b_gnt_busy", gnt[1], 1'b0);
    end
    @(negedge clk);
    check1("b_gnt_again", gnt[1], 1'b1);
    drain();

    // instance B: load/store become no-ops
    issue(1, 2'd2, 32'h0000_0020, 32'h1234_5678, 0, 0, 32'h0, 1'b0);
    drain();
    issue(1, 2'd1, 32'h1000_0006, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    drain();

    // instance B random mix with held requests
    for (int k = 0; k < 30; k++) begin
      o = 2'($urandom_range(0, 3));
      issue(1, o, $urandom, $urandom, 0, 0, $urandom, (k < 29) && ($urandom_range(0, 1) == 0));
    end
    req[1] = 1'b0;
    prev_hold[1] = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
